// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI requester arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam int DEF_GAP_CYCLES = 20;
  localparam int DEF_TIMEOUT    = 50000;

  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr.sv
// Round-robin pick: lowest requesting index at or above the pointer,
// wrapping modulo NREQ.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_oh;
  logic            w_found;

  always_comb begin
    w_oh    = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[IW'(rr_wrap(int'(i_ptr) + i, NREQ))]) begin
        w_found = 1'b1;
        w_oh[IW'(rr_wrap(int'(i_ptr) + i, NREQ))] = 1'b1;
      end
    end
  end

  always_comb begin
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_oh[k]) o_idx = IW'(k);
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one spi_ctrl between NREQ requesters: round-robin grant,
// spi_over completion, CS-high gap and hung-transaction timeout.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TO_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_tx,
  input  logic [NREQ-1:0] req_rx,
  input  logic [NREQ-1:0] req_mode,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            busy,
  output logic            spi_tx_en,
  output logic            spi_rx_en,
  output logic            mode_select,
  input  logic            spi_over
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_ptr;
  logic [TO_W-1:0] r_to_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_tx_l;
  logic            r_rx_l;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_tx_en;
  logic            r_rx_en;
  logic            r_mode;
  logic            r_ov_s1;
  logic            r_ov_s2;
  logic            r_ov_d;

  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [NREQ-1:0] w_idx_oh;
  logic [IW-1:0]   w_next_ptr;
  logic            w_ov_rise;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_idx_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
  assign w_next_ptr = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
  // Only a fresh edge counts, so a level left high from a previous frame is ignored.
  assign w_ov_rise  = r_ov_s2 & ~r_ov_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_tx_l    <= 1'b0;
      r_rx_l    <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
      r_mode    <= 1'b0;
      r_ov_s1   <= 1'b0;
      r_ov_s2   <= 1'b0;
      r_ov_d    <= 1'b0;
    end else begin
      r_ov_s1 <= spi_over;
      r_ov_s2 <= r_ov_s1;
      r_ov_d  <= r_ov_s2;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_idx   <= w_pick;
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (req_tx[r_idx] | req_rx[r_idx]) begin
            r_tx_l  <= req_tx[r_idx];
            r_rx_l  <= req_rx[r_idx];
            r_mode  <= req_mode[r_idx];
            r_gnt   <= w_idx_oh;
            r_state <= ST_START;
          end else begin
            r_err     <= w_idx_oh;
            r_ptr     <= w_next_ptr;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end
        end
        ST_START: begin
          r_tx_en  <= r_tx_l;
          r_rx_en  <= r_rx_l;
          r_to_cnt <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (w_ov_rise) begin
            r_tx_en <= 1'b0;
            r_rx_en <= 1'b0;
            r_done  <= w_idx_oh;
            r_state <= ST_DONE;
          end else if (r_to_cnt == TO_LAST) begin
            r_tx_en   <= 1'b0;
            r_rx_en   <= 1'b0;
            r_err     <= w_idx_oh;
            r_gnt     <= '0;
            r_ptr     <= w_next_ptr;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end
        end
        ST_DONE: begin
          r_gnt     <= '0;
          r_ptr     <= w_next_ptr;
          r_gap_cnt <= '0;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
          else r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign spi_tx_en   = r_tx_en;
  assign spi_rx_en   = r_rx_en;
  assign mode_select = r_mode;

endmodule
